// File: rtl/half_fp_div.sv
// IEEE-754 binary16 divider: special-operand decode, radix-2 restoring
// significand division (one quotient bit per clock), round-to-nearest-even.
module half_fp_div (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPECIAL = 2'd1,
        DIVIDE  = 2'd2,
        ROUND   = 2'd3
    } state_t;

    // Flag vector order: {invalid, div_by_zero, overflow, underflow, inexact}
    localparam logic [4:0] FLG_NONE = 5'b00000;
    localparam logic [4:0] FLG_INV  = 5'b10000;
    localparam logic [4:0] FLG_DBZ  = 5'b01000;
    localparam logic [4:0] FLG_OVF  = 5'b00101;
    localparam logic [4:0] FLG_UNF  = 5'b00011;
    localparam logic [4:0] FLG_INX  = 5'b00001;

    function automatic logic is_nan(input logic [15:0] v);
        return (v[14:10] == 5'd31) && (v[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] v);
        return (v[14:10] == 5'd31) && (v[9:0] == 10'd0);
    endfunction

    function automatic logic is_zero(input logic [15:0] v);
        return (v[14:10] == 5'd0);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [11:0] rem_q, rem_d;
    logic [13:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  flags_q, flags_d;

    logic        sign_s, spec_hit_s;
    logic [15:0] spec_res_s;
    logic [4:0]  spec_flags_s;
    logic [11:0] mb_s, diff_s, rem_sel_s;
    logic        ge_s;
    logic        q13_s, g_s, s_s, rnd_up_s, carry_s, ovf_s, unf_s;
    logic [9:0]  frac_pre_s, frac_fin_s;
    logic [10:0] frac_sum_s;
    logic [6:0]  e_pre_s, e_fin_s;

    // Special-operand classification in priority order
    always_comb begin
        sign_s       = a_q[15] ^ b_q[15];
        spec_hit_s   = 1'b1;
        spec_res_s   = 16'h0000;
        spec_flags_s = FLG_NONE;
        if (is_nan(a_q) || is_nan(b_q)) begin
            spec_res_s = 16'h7E00;
        end else if ((is_inf(a_q) && is_inf(b_q)) || (is_zero(a_q) && is_zero(b_q))) begin
            spec_res_s   = 16'h7E00;
            spec_flags_s = FLG_INV;
        end else if (is_inf(a_q)) begin
            spec_res_s = {sign_s, 15'h7C00};
        end else if (is_inf(b_q)) begin
            spec_res_s = {sign_s, 15'h0000};
        end else if (is_zero(b_q)) begin
            spec_res_s   = {sign_s, 15'h7C00};
            spec_flags_s = FLG_DBZ;
        end else if (is_zero(a_q)) begin
            spec_res_s = {sign_s, 15'h0000};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // One restoring-division step and the normalise/round datapath
    always_comb begin
        mb_s      = {2'b01, b_q[9:0]};
        ge_s      = (rem_q >= mb_s);
        diff_s    = rem_q - mb_s;
        rem_sel_s = ge_s ? diff_s : rem_q;

        q13_s      = quo_q[13];
        frac_pre_s = q13_s ? quo_q[12:3] : quo_q[11:2];
        g_s        = q13_s ? quo_q[2] : quo_q[1];
        s_s        = (q13_s ? (|quo_q[1:0]) : quo_q[0]) | (rem_q != 12'd0);
        e_pre_s    = {2'b00, a_q[14:10]} - {2'b00, b_q[14:10]} + (q13_s ? 7'd15 : 7'd14);
        // A carry out of the 10-bit fraction is the same as a carry out of the 11-bit significand
        rnd_up_s   = g_s & (s_s | frac_pre_s[0]);
        frac_sum_s = {1'b0, frac_pre_s} + {10'd0, rnd_up_s};
        carry_s    = frac_sum_s[10];
        frac_fin_s = frac_sum_s[9:0];
        e_fin_s    = carry_s ? (e_pre_s + 7'd1) : e_pre_s;
        ovf_s      = ($signed(e_fin_s) >= $signed(7'sd31));
        unf_s      = ($signed(e_fin_s) <= $signed(7'sd0));
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    busy_d  = 1'b1;
                    state_d = SPECIAL;
                end else begin
                    busy_d = 1'b0;
                end
            end
            SPECIAL: begin
                if (spec_hit_s) begin
                    res_d   = spec_res_s;
                    flags_d = spec_flags_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d   = {2'b01, a_q[9:0]};
                    quo_d   = 14'd0;
                    cnt_d   = 4'd13;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_sel_s << 1;
                quo_d = (quo_q << 1) | {13'd0, ge_s};
                if (cnt_q == 4'd0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ROUND: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (ovf_s) begin
                    res_d   = {sign_s, 15'h7C00};
                    flags_d = FLG_OVF;
                end else if (unf_s) begin
                    res_d   = {sign_s, 15'h0000};
                    flags_d = FLG_UNF;
                end else begin
                    res_d   = {sign_s, e_fin_s[4:0], frac_fin_s};
                    flags_d = (g_s | s_s) ? FLG_INX : FLG_NONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            rem_q   <= 12'd0;
            quo_q   <= 14'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= 16'd0;
            flags_q <= 5'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = res_q;
    assign invalid     = flags_q[4];
    assign div_by_zero = flags_q[3];
    assign overflow    = flags_q[2];
    assign underflow   = flags_q[1];
    assign inexact     = flags_q[0];

endmodule

// File: doc/half_fp_div.md
# half_fp_div

Multi-cycle IEEE-754 binary16 divider, the inverse companion to the half-precision multiplier in the FPU datapath. It accepts a dividend/divisor pair on a start pulse, resolves special operands, and computes the 11-bit significand quotient with a radix-2 restoring divider, one bit per clock. It then normalizes and rounds to nearest-even, and returns the result with a one-cycle done pulse and exception flags.

## Interface
- No parameters (format fixed: 1 sign, 5 exponent (bias 15), 10 fraction).
- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  16  binary16 numerator; sampled with start.
- divisor  input  16  binary16 denominator; sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: quotient/flags valid.
- quotient  output  16  binary16 result; held until the next accepted start.
- invalid, div_by_zero, overflow, underflow, inexact  output  1 each  exception flags; they update with quotient and hold with it.

## Operation
- States: IDLE, SPECIAL, DIVIDE, ROUND.
- IDLE: start=1 registers operands, sets busy, goes to SPECIAL. start while busy=1 is ignored.
- SPECIAL decode. An exponent field of 0 counts as zero; subnormal inputs are flushed. Priority order:
  - Either operand NaN -> 0x7E00.
  - inf/inf or 0/0 -> 0x7E00, invalid=1.
  - inf/finite -> ±inf (0x7C00|sign).
  - finite/inf -> ±0.
  - nonzero/0 -> ±inf, div_by_zero=1.
  - 0/nonzero -> ±0.
- Sign is always dividend[15]^divisor[15], except for NaN results.
- A special result loads outputs and returns to IDLE. Otherwise go to DIVIDE with a 4-bit counter = 13.
- DIVIDE (14 cycles):
  - Operand significands are ma={1,frac_a} and mb={1,frac_b}.
  - Partial remainder is 12 bits, initialised to ma.
  - Each cycle: trial = rem - mb. If non-negative, rem=trial and q bit=1; else q bit=0. Then rem<<=1 and q shifts in LSB-first order.
  - After 14 bits, q = floor(ma·2^13/mb), in [2^12, 2^14).
- ROUND (1 cycle):
  - If q[13]=1: sig=q[13:3], g=q[2], s=|q[1:0] | (rem≠0), e=ea-eb+15.
  - Else: sig=q[12:2], g=q[1], s=q[0] | (rem≠0), e=ea-eb+14.
  - e is a signed 7-bit value.
  - Round to nearest even: increment sig when g & (s | sig[0]). A carry out of sig sets sig=0x400 and e+=1.
  - inexact = g|s.
  - e≥31 -> ±inf with overflow=1 and inexact=1.
  - e≤0 -> ±0 with underflow=1 and inexact=1 (no subnormal output).
  - Otherwise quotient={sign, e[4:0], sig[9:0]}.
- Flags not raised by the current operation are cleared when the result loads.

## Timing
- Edges are numbered from E1, the edge that samples start.
- Special path: result loads at E2. done=1 and busy=0 for the following cycle.
- Normal path: E3–E16 perform the 14 divide iterations; the result loads at E17. done=1 and busy=0 for the following cycle.
- Latency is therefore 2 cycles (special) or 17 cycles (normal).
- busy is high from after E1 until the result-load edge.
- done is high exactly one cycle. A start presented during the done cycle is accepted, giving back-to-back operation.
- Reset values: busy=0, done=0, quotient=0x0000, all flags 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.
- Operand inputs may change freely after E1 without affecting the result.

## Test plan
- Basic quotient: 0x4000/0x3C00 (2/1) -> quotient=0x4000, all flags 0. done high exactly the cycle after E17, busy high E1–E17.
- Inexact rounding: 0x3C00/0x4200 (1/3) -> 0x3555, inexact=1. 0xC500/0x4100 (-5/2.5) -> 0xC000, flags 0.
- Special cases, each with done after E2:
  - 0x3C00/0x0000 -> 0x7C00, div_by_zero=1.
  - 0x0000/0x0000 -> 0x7E00, invalid=1.
  - 0x7C00/0x4000 -> 0x7C00.
  - 0x7E01/0x3C00 -> 0x7E00.
- Range limits:
  - 0x7BFF/0x3800 (65504/0.5) -> 0x7C00, overflow=1, inexact=1.
  - 0x0400/0x4000 -> 0x0000, underflow=1, inexact=1.
- Handshake and reset:
  - start pulsed again at E5 during a divide is ignored; the original result arrives at E17.
  - start held during the done cycle launches a second division.
  - n_rst low at E8 -> all outputs return to reset values asynchronously, and no done pulse follows.
